// File: rtl/i2c_fifo.sv
// i2c_fifo: synchronous first-word-fall-through byte FIFO between the APB register
// block and the I2C master core (used once for TX, once for RX).
//
// Ports:
//   clk               system clock, all state on posedge
//   i2c_reset_n       asynchronous active-low reset
//   fifo_clear        synchronous flush pulse, wins over rd/wr in the same cycle
//   fifo_wr_en        push fifo_data_in
//   fifo_data_in      write data
//   fifo_rd_en        pop the head entry
//   fifo_data_out     head entry, combinational (FWFT); 0 while empty
//   fifo_full         count == depth           (registered)
//   fifo_empty        count == 0               (registered)
//   fifo_almost_full  count >= AFULL_LVL       (registered)
//   fifo_almost_empty count <= AEMPTY_LVL      (registered)
//   fifo_count        occupancy 0..depth       (registered)
//   fifo_overflow     sticky: write while full without a read
//   fifo_underflow    sticky: read while empty
module i2c_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AFULL_LVL  = 14,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  i2c_reset_n,
  input  logic                  fifo_clear,
  input  logic                  fifo_wr_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfullCnt  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AemptyCnt = AEMPTY_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] One       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (!((AEMPTY_LVL < AFULL_LVL) && (AFULL_LVL <= DEPTH))) begin : g_param_check
    $error("i2c_fifo: need AEMPTY_LVL < AFULL_LVL <= 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra bit; only the low ADDR_WIDTH bits index storage.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  logic wr_acc;
  logic rd_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc = fifo_wr_en && (!full_q || fifo_rd_en);
  assign rd_acc = fifo_rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (fifo_wr_en & full_q & ~fifo_rd_en);
    udf_d    = udf_q | (fifo_rd_en & empty_q);

    if (wr_acc) wr_ptr_d = wr_ptr_q + One;
    if (rd_acc) rd_ptr_d = rd_ptr_q + One;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase

    if (fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfullCnt);
    aempty_d = (count_d <= AemptyCnt);
  end

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset; a flush suppresses the same-cycle write.
  always_ff @(posedge clk) begin
    if (wr_acc && !fifo_clear) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_data_in;
    end
  end

  assign fifo_data_out     = empty_q ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign fifo_full         = full_q;
  assign fifo_empty        = empty_q;
  assign fifo_almost_full  = afull_q;
  assign fifo_almost_empty = aempty_q;
  assign fifo_count        = count_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;

endmodule
